fft16_stream_ctrl: RTL and testbench

// Sequencer for the 16-point radix-4 streaming FFT datapath (signalSelect -> BUTTERFLY_STAGE_1 ->

---
 rtl/fft16_stream_ctrl_if.sv | 30 +++
 rtl/fft16_stream_ctrl.sv | 116 +++++++++++
 tb/tb_fft16_stream_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fft16_stream_ctrl_if.sv
// Handshake and strobe bundle between the FFT stream controller and its neighbours.
// The slave side is the controller; the master side is the upstream source and downstream sink.
interface fft16_stream_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic             cfg_drain_en;
    logic             pipe_en;
    logic             in_zero;
    logic [1:0]       q;
    logic [1:0]       grp;
    logic             out_valid;
    logic             out_sof;
    logic             out_eof;
    logic             busy;
    logic [CNT_W-1:0] frame_cnt;

    modport master (
        output in_valid, cfg_drain_en,
        input  in_ready, pipe_en, in_zero, q, grp,
        input  out_valid, out_sof, out_eof, busy, frame_cnt
    );

    modport slave (
        input  in_valid, cfg_drain_en,
        output in_ready, pipe_en, in_zero, q, grp,
        output out_valid, out_sof, out_eof, busy, frame_cnt
    );
endinterface

// File: rtl/fft16_stream_ctrl.sv
// Sequencer for the 16-point radix-4 streaming FFT datapath.
// Accepts samples, drives the global datapath enable and phase, tracks frame
// tags through the pipe and flushes the last frame with zero bubbles.
module fft16_stream_ctrl #(
    parameter int N_PTS    = 16,
    parameter int LOG2N    = 4,
    parameter int PIPE_LAT = 12,
    parameter int CNT_W    = 16
) (
    input logic                clk,
    input logic                reset,
    fft16_stream_ctrl_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N_PTS - 1);

    logic [1:0]          state_q, state_d;
    logic [LOG2N-1:0]    sample_cnt_q, sample_cnt_d;
    logic [PIPE_LAT-1:0] tag_v_q, tag_v_d;
    logic [PIPE_LAT-1:0] tag_s_q, tag_s_d;
    logic [PIPE_LAT-1:0] tag_e_q, tag_e_d;
    logic                out_valid_q, out_valid_d;
    logic                out_sof_q, out_sof_d;
    logic                out_eof_q, out_eof_d;
    logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;

    logic accept;
    logic bubble;
    logic pipe_en;

    // Accept, drain-bubble decision and the resulting datapath enable
    always_comb begin
        accept  = bus.in_valid & ~reset;
        bubble  = ~reset & (state_q == ST_DRAIN) & bus.cfg_drain_en
                  & (|tag_v_q) & ~bus.in_valid;
        pipe_en = accept | bubble;
    end

    assign bus.in_ready  = ~reset;
    assign bus.pipe_en   = pipe_en;
    assign bus.in_zero   = bubble;
    assign bus.q         = (reset | bubble) ? 2'b00 : sample_cnt_q[1:0];
    assign bus.grp       = reset ? 2'b00 : sample_cnt_q[3:2];
    assign bus.busy      = ~reset & ((state_q != ST_IDLE) | (|tag_v_q));
    assign bus.out_valid = out_valid_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.out_eof   = out_eof_q;
    assign bus.frame_cnt = frame_cnt_q;

    // Next-state: sample counter, tag pipe, output strobes, frame counter, FSM
    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        tag_v_d      = tag_v_q;
        tag_s_d      = tag_s_q;
        tag_e_d      = tag_e_q;

        if (pipe_en) begin
            tag_v_d = {tag_v_q[PIPE_LAT-2:0], accept};
            tag_s_d = {tag_s_q[PIPE_LAT-2:0], accept & (sample_cnt_q == '0)};
            tag_e_d = {tag_e_q[PIPE_LAT-2:0], accept & (sample_cnt_q == CNT_LAST)};
        end

        if (accept) begin
            sample_cnt_d = sample_cnt_q + LOG2N'(1);
        end

        out_valid_d = pipe_en & tag_v_q[PIPE_LAT-1];
        out_sof_d   = pipe_en & tag_s_q[PIPE_LAT-1];
        out_eof_d   = pipe_en & tag_e_q[PIPE_LAT-1];
        frame_cnt_d = frame_cnt_q + CNT_W'(out_eof_q);

        // DRAIN exits on the next tag vector so busy drops the cycle the last result emerges
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_FILL;
            end
            ST_FILL: begin
                if (accept && (sample_cnt_q == CNT_LAST)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (accept)          state_d = ST_FILL;
                else if (~|tag_v_d)  state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sample_cnt_q <= '0;
            tag_v_q      <= '0;
            tag_s_q      <= '0;
            tag_e_q      <= '0;
            out_valid_q  <= 1'b0;
            out_sof_q    <= 1'b0;
            out_eof_q    <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            tag_v_q      <= tag_v_d;
            tag_s_q      <= tag_s_d;
            tag_e_q      <= tag_e_d;
            out_valid_q  <= out_valid_d;
            out_sof_q    <= out_sof_d;
            out_eof_q    <= out_eof_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end
endmodule

// File: tb/tb_fft16_stream_ctrl.sv
// Self-checking bench for fft16_stream_ctrl: directed table, hand sequences
// for multi-cycle corners, and randomized traffic against a sample-list model.
module tb_fft16_stream_ctrl;
    localparam int N_PTS    = 16;
    localparam int PIPE_LAT = 12;

    logic clk;
    logic rst;

    fft16_stream_ctrl_if #(.CNT_W(16)) ifc ();

    fft16_stream_ctrl #(
        .N_PTS(16), .LOG2N(4), .PIPE_LAT(12), .CNT_W(16)
    ) dut (
        .clk  (clk),
        .reset(rst),
        .bus  (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int tcount   = 0;
    bit armed    = 1'b0;

    // reference model: accepted samples in flight, each with its advance count
    typedef struct {
        int adv;
        bit s;
        bit e;
    } item_t;
    item_t       items[$];
    int          mpos;
    bit          m_ov, m_sof, m_eof;
    logic [15:0] m_fc;

    // last observed DUT values
    bit          o_pe, o_iz, o_ov, o_sof, o_eof, o_busy;
    logic [1:0]  o_q, o_grp;
    logic [15:0] o_fc;

    // recorded event cycles for hand sequences
    int ovs[$];
    int sofs[$];
    int eofs[$];
    int izs[$];
    int pes[$];

    function automatic void chk(string name, int cyc, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    endfunction

    function automatic void model_comb(input bit r, input bit v, input bit d,
                                       output logic [7:0] exp, output bit pe);
        bit rdy, iz, busy, drain;
        int qq, gg;
        if (r) begin
            exp = '0;
            pe  = 1'b0;
        end else begin
            rdy   = 1'b1;
            drain = (mpos == 0) && (items.size() > 0);
            pe    = v | (drain & d & ~v);
            iz    = pe & ~v;
            qq    = iz ? 0 : mpos % 4;
            gg    = mpos / 4;
            busy  = !((mpos == 0) && (items.size() == 0));
            exp   = {rdy, pe, iz, 2'(qq), 2'(gg), busy};
        end
    endfunction

    function automatic void model_step(input bit r, input bit v, input bit pe);
        item_t keep[$];
        bit n_ov, n_sof, n_eof;
        if (r) begin
            mpos = 0;
            items.delete();
            m_ov = 0; m_sof = 0; m_eof = 0;
            m_fc = '0;
        end else begin
            m_fc = m_fc + 16'(m_eof);
            n_ov = 0; n_sof = 0; n_eof = 0;
            if (pe) begin
                foreach (items[i]) begin
                    if (items[i].adv == PIPE_LAT - 1) begin
                        n_ov = 1; n_sof = items[i].s; n_eof = items[i].e;
                    end else begin
                        keep.push_back('{items[i].adv + 1, items[i].s, items[i].e});
                    end
                end
                items = keep;
            end
            if (v) begin
                items.push_back('{0, mpos == 0, mpos == N_PTS - 1});
                mpos = (mpos + 1) % N_PTS;
            end
            m_ov = n_ov; m_sof = n_sof; m_eof = n_eof;
        end
    endfunction

    // one clock: drive at negedge, sample 1 ns later, advance model, wait next negedge
    task automatic tick(input bit r, input bit v, input bit d);
        logic [7:0] exp;
        bit pe;
        rst = r;
        ifc.in_valid = v;
        ifc.cfg_drain_en = d;
        #1;
        o_pe = ifc.pipe_en; o_iz = ifc.in_zero; o_q = ifc.q; o_grp = ifc.grp;
        o_ov = ifc.out_valid; o_sof = ifc.out_sof; o_eof = ifc.out_eof;
        o_busy = ifc.busy; o_fc = ifc.frame_cnt;
        model_comb(r, v, d, exp, pe);
        if (armed) begin
            chk("comb", tcount, 32'({ifc.in_ready, ifc.pipe_en, ifc.in_zero, ifc.q, ifc.grp, ifc.busy}), 32'(exp));
            chk("strobes", tcount, 32'({ifc.out_valid, ifc.out_sof, ifc.out_eof}), 32'({m_ov, m_sof, m_eof}));
            chk("frame_cnt", tcount, 32'(ifc.frame_cnt), 32'(m_fc));
        end
        model_step(r, v, pe);
        tcount++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
    endtask

    // scenario runner: stimulus chosen by kind, events recorded per local cycle
    task automatic scen(input int kind, input int ncyc);
        bit v, d;
        ovs.delete(); sofs.delete(); eofs.delete(); izs.delete(); pes.delete();
        for (int c = 0; c < ncyc; c++) begin
            d = 1'b1;
            case (kind)
                0: v = (c < 32);
                1: v = (c < 20) && !((c >= 5) && (c <= 8));
                2: v = (c < 16) || ((c >= 20) && (c < 36));
                default: begin
                    v = (c < 16);
                    d = (c >= 40);
                end
            endcase
            tick(1'b0, v, d);
            if (o_ov)  ovs.push_back(c);
            if (o_sof) sofs.push_back(c);
            if (o_eof) eofs.push_back(c);
            if (o_iz)  izs.push_back(c);
            if (o_pe)  pes.push_back(c);
            if (kind == 0 && c == 45) chk("two_frames_fc", c, 32'(o_fc), 32'd2);
            if (kind == 1 && c >= 5 && c <= 8) begin
                chk("gap_pe", c, 32'(o_pe), 32'd0);
                chk("gap_q", c, 32'(o_q), 32'd1);
            end
            if (kind == 2 && c == 20)
                chk("resume_q_pe_iz", c, 32'({o_q, o_pe, o_iz}), 32'({2'd0, 1'b1, 1'b0}));
            if (kind == 3 && c == 39) chk("nodrain_busy", c, 32'(o_busy), 32'd1);
        end
    endtask

    typedef struct {
        int cyc;
        bit v;
        bit pe, iz;
        bit [1:0] q, grp;
        bit ov, sof, eof, busy;
        int fc;
    } vec_t;
    vec_t tbl[8];

    initial begin
        int c;
        bit pv;
        rst = 1'b1;
        ifc.in_valid = 1'b0;
        ifc.cfg_drain_en = 1'b1;
        model_step(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        tick(1'b1, 1'b0, 1'b1);
        armed = 1'b1;

        // reset held with in_valid high: nothing accepted, outputs zero
        tick(1'b1, 1'b1, 1'b1);
        chk("rst_outs", tcount, 32'({o_pe, o_iz, o_q, o_grp, o_ov, o_sof, o_eof, o_busy}), 32'd0);
        tick(1'b1, 1'b1, 1'b1);
        chk("rst_outs2", tcount, 32'({o_pe, o_iz, o_q, o_grp, o_ov, o_busy, o_fc}), 32'd0);
        tick(1'b0, 1'b1, 1'b1);
        chk("first_accept", tcount, 32'({o_pe, o_q, o_grp}), 32'({1'b1, 2'd0, 2'd0}));

        // one frame then auto-drain, hand-derived checkpoints
        tbl[0] = '{0,  1, 1, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0};
        tbl[1] = '{5,  1, 1, 0, 2'd1, 2'd1, 0, 0, 0, 1, 0};
        tbl[2] = '{13, 1, 1, 0, 2'd1, 2'd3, 1, 1, 0, 1, 0};
        tbl[3] = '{15, 1, 1, 0, 2'd3, 2'd3, 1, 0, 0, 1, 0};
        tbl[4] = '{16, 0, 1, 1, 2'd0, 2'd0, 1, 0, 0, 1, 0};
        tbl[5] = '{27, 0, 1, 1, 2'd0, 2'd0, 1, 0, 0, 1, 0};
        tbl[6] = '{28, 0, 0, 0, 2'd0, 2'd0, 1, 0, 1, 0, 0};
        tbl[7] = '{29, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 1};
        do_reset();
        c  = 0;
        pv = 1'b1;
        for (int r = 0; r < 8; r++) begin
            while (c < tbl[r].cyc) begin
                tick(1'b0, pv, 1'b1);
                c++;
            end
            tick(1'b0, tbl[r].v, 1'b1);
            chk("tbl_outs", c,
                32'({o_pe, o_iz, o_q, o_grp, o_ov, o_sof, o_eof, o_busy}),
                32'({tbl[r].pe, tbl[r].iz, tbl[r].q, tbl[r].grp, tbl[r].ov, tbl[r].sof, tbl[r].eof, tbl[r].busy}));
            chk("tbl_fc", c, 32'(o_fc), 32'(tbl[r].fc));
            pv = tbl[r].v;
            c++;
        end

        // two back-to-back frames
        do_reset();
        scen(0, 60);
        chk("two_first_ov", 0, 32'(ovs.size() > 0 ? ovs[0] : -1), 32'd13);
        chk("two_ov_n", 0, 32'(ovs.size()), 32'd32);
        chk("two_sof", 0, 32'({sofs.size() == 2, 8'(sofs.size() > 1 ? sofs[0] : 0), 8'(sofs.size() > 1 ? sofs[1] : 0)}), 32'({1'b1, 8'd13, 8'd29}));
        chk("two_eof", 0, 32'({eofs.size() == 2, 8'(eofs.size() > 1 ? eofs[0] : 0), 8'(eofs.size() > 1 ? eofs[1] : 0)}), 32'({1'b1, 8'd28, 8'd44}));

        // mid-frame gap: no bubbles, results shifted by four
        do_reset();
        scen(1, 45);
        chk("gap_first_ov", 0, 32'(ovs.size() > 0 ? ovs[0] : -1), 32'd17);
        chk("gap_ov_n", 0, 32'(ovs.size()), 32'd16);
        chk("gap_eof", 0, 32'(eofs.size() > 0 ? eofs[0] : -1), 32'd32);

        // new frame arrives during drain
        do_reset();
        scen(2, 60);
        chk("resume_bubbles", 0, 32'({8'(izs.size() > 3 ? izs[0] : 0), 8'(izs.size() > 3 ? izs[3] : 0), 8'(izs.size() > 4 ? izs[4] : 0)}), 32'({8'd16, 8'd19, 8'd36}));
        chk("resume_eof_n", 0, 32'(eofs.size()), 32'd2);

        // drain disabled: pipe freezes until the drain is re-enabled
        do_reset();
        scen(3, 70);
        chk("nodrain_pe_n", 0, 32'(pes.size()), 32'd28);
        chk("nodrain_eof", 0, 32'(eofs.size() > 0 ? eofs[0] : -1), 32'd52);
        chk("nodrain_ov_n", 0, 32'(ovs.size()), 32'd16);

        // randomized traffic against the model
        do_reset();
        pv = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) pv = ~pv;
            tick($urandom_range(0, 699) == 0, $urandom_range(0, 3) != 0 && ($urandom_range(0, 99) > 6), pv);
        end
        for (int i = 0; i < 30; i++) tick(1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
